line_buf_writer: RTL and testbench

//  Write side of the 4-bank rotating line buffer that feeds conv_layer. Takes raster video
//  (de + RGB pixel), writes line n into bank n mod 4 and starts the reader once 3 lines are stored.

---
 rtl/line_buf_writer.sv | 138 +++++++++++++
 tb/tb_line_buf_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_writer.sv
// Write side of the 4-bank rotating line buffer in front of conv_layer.
// Line n of a frame goes to bank n mod 4; the reader is started once three lines are stored.
module line_buf_writer #(
  parameter int          bit_depth    = 8,
  parameter logic [10:0] image_width  = 11'd1920,
  parameter logic [10:0] image_height = 11'd1080
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   vsync_in,
  input  logic                   de_in,
  input  logic [bit_depth*3-1:0] pix_in,
  input  logic                   fin_rd,
  output logic [10:0]            wr_addr,
  output logic [bit_depth*3-1:0] wr_data,
  output logic                   in0_wren,
  output logic                   in1_wren,
  output logic                   in2_wren,
  output logic                   in3_wren,
  output logic                   start_rd,
  output logic                   frame_done,
  output logic                   ovf_err,
  output logic                   len_err
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t                 state_q;
  logic                   dePrev_q;
  logic                   skip_q;
  logic [11:0]            pixCnt_q;
  logic [10:0]            wrLine_q;
  logic [10:0]            rdRows_q;
  logic [10:0]            wrAddr_q;
  logic [bit_depth*3-1:0] wrData_q;
  logic [3:0]             wren_q;
  logic                   startRd_q;
  logic                   frameDone_q;
  logic                   ovfErr_q;
  logic                   lenErr_q;

  logic        deRise;
  logic        deFall;
  logic        inFrame;
  logic        ovfHit;
  logic        skipNow;
  logic        rdCount;
  logic [11:0] curIdx;
  logic [10:0] lineDiff;
  logic [10:0] rdRows_d;

  // Edge detection and the overrun test all work on pre-update register values,
  // so a fin_rd landing on a de_in edge is counted without disturbing that edge's decision.
  always_comb begin
    deRise   = de_in & ~dePrev_q;
    deFall   = ~de_in & dePrev_q;
    inFrame  = (state_q == FILL) || (state_q == RUN);
    curIdx   = dePrev_q ? pixCnt_q : 12'd0;
    lineDiff = wrLine_q - rdRows_q;
    ovfHit   = deRise && (state_q == RUN) && (lineDiff >= 11'd4);
    skipNow  = deRise ? ovfHit : skip_q;
    rdCount  = fin_rd & startRd_q;
    rdRows_d = rdCount ? rdRows_q + 11'd1 : rdRows_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= IDLE;
      dePrev_q    <= 1'b0;
      skip_q      <= 1'b0;
      pixCnt_q    <= '0;
      wrLine_q    <= '0;
      rdRows_q    <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wren_q      <= '0;
      startRd_q   <= 1'b0;
      frameDone_q <= 1'b0;
      ovfErr_q    <= 1'b0;
      lenErr_q    <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      wren_q      <= '0;
      dePrev_q    <= de_in;
      wrAddr_q    <= curIdx[10:0];
      wrData_q    <= pix_in;
      if (de_in) begin
        pixCnt_q <= (&curIdx) ? curIdx : curIdx + 12'd1;
      end
      if (vsync_in) begin
        // A frame start always wins; an unfinished frame counts as a length fault.
        state_q   <= FILL;
        wrLine_q  <= '0;
        rdRows_q  <= '0;
        skip_q    <= 1'b0;
        startRd_q <= 1'b0;
        if (state_q != IDLE) lenErr_q <= 1'b1;
      end else begin
        rdRows_q <= rdRows_d;
        if (deRise) skip_q <= ovfHit;
        if (ovfHit) ovfErr_q <= 1'b1;
        if (inFrame && de_in) begin
          if (curIdx < {1'b0, image_width}) begin
            if (!skipNow) wren_q[wrLine_q[1:0]] <= 1'b1;
          end else begin
            lenErr_q <= 1'b1;
          end
        end
        if (inFrame && deFall) begin
          wrLine_q <= wrLine_q + 11'd1;
          if (pixCnt_q != {1'b0, image_width}) lenErr_q <= 1'b1;
          if ((state_q == FILL) && (wrLine_q == 11'd2)) begin
            state_q   <= RUN;
            startRd_q <= 1'b1;
          end
          if ((state_q == RUN) && (wrLine_q == image_height - 11'd1)) state_q <= DRAIN;
        end
        if ((state_q == DRAIN) && rdCount && (rdRows_d >= image_height - 11'd2)) begin
          state_q     <= IDLE;
          startRd_q   <= 1'b0;
          frameDone_q <= 1'b1;
        end
      end
    end
  end

  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign in0_wren   = wren_q[0];
  assign in1_wren   = wren_q[1];
  assign in2_wren   = wren_q[2];
  assign in3_wren   = wren_q[3];
  assign start_rd   = startRd_q;
  assign frame_done = frameDone_q;
  assign ovf_err    = ovfErr_q;
  assign len_err    = lenErr_q;

endmodule

// File: tb/tb_line_buf_writer.sv
// Bench for line_buf_writer: a line-level table of frame scenarios, a mid-line reset sequence
// and random traffic, all checked cycle by cycle against a frame/line accounting model.
module tb_line_buf_writer;

  localparam int BD = 8;
  localparam int PW = BD * 3;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk      = 1'b0;
  logic          RESET    = 1'b0;
  logic          vsync_in = 1'b0;
  logic          de_in    = 1'b0;
  logic          fin_rd   = 1'b0;
  logic [PW-1:0] pix_in   = '0;
  logic [10:0]   wr_addr;
  logic [PW-1:0] wr_data;
  logic          in0_wren, in1_wren, in2_wren, in3_wren;
  logic          start_rd, frame_done, ovf_err, len_err;

  line_buf_writer #(
    .bit_depth   (BD),
    .image_width (11'd8),
    .image_height(11'd6)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .pix_in    (pix_in),
    .fin_rd    (fin_rd),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .in0_wren  (in0_wren),
    .in1_wren  (in1_wren),
    .in2_wren  (in2_wren),
    .in3_wren  (in3_wren),
    .start_rd  (start_rd),
    .frame_done(frame_done),
    .ovf_err   (ovf_err),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: frame active (lines still counted), reader running, line/row tallies.
  bit mFrame, mReading, mPrevDe, mBlocked, mOvf, mLen;
  int mLines, mRows, mPixCount;

  int wrCnt[4];
  bit doneSeen;

  typedef struct {
    bit vs;
    int finBefore;
    int len;
    int expBank;
    int expWrites;
    bit expStart;
    bit expDone;
    bit expOvf;
    bit expLen;
  } row_t;

  row_t rows[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit vs, input bit de, input logic [PW-1:0] pix, input bit fin);
    bit expDone = 1'b0;
    int expBank = -1;
    int idx, diff;
    bit rise, fall, preFrame, preReading;
    logic [3:0] expWren;
    RESET = rst; vsync_in = vs; de_in = de; pix_in = pix; fin_rd = fin;
    rise       = de && !mPrevDe;
    fall       = !de && mPrevDe;
    idx        = mPrevDe ? mPixCount : 0;
    preFrame   = mFrame;
    preReading = mReading;
    if (rst) begin
      mFrame = 0; mReading = 0; mBlocked = 0; mOvf = 0; mLen = 0;
      mLines = 0; mRows = 0; mPixCount = 0;
    end else if (vs) begin
      if (mFrame || mReading) mLen = 1;
      mFrame = 1; mReading = 0; mLines = 0; mRows = 0; mBlocked = 0;
    end else begin
      if (rise) begin
        diff = mLines - mRows;
        if (diff < 0) diff += 2048;
        mBlocked = mFrame && mReading && (diff >= 4);
        if (mBlocked) mOvf = 1;
      end
      if (mFrame && de) begin
        if (idx < W) begin
          if (!mBlocked) expBank = mLines % 4;
        end else begin
          mLen = 1;
        end
      end
      if (fall && mFrame) begin
        if (mPixCount != W) mLen = 1;
        mLines++;
        if (mLines == 3 && !mReading) mReading = 1;
        if (mLines == H) mFrame = 0;
      end
      if (fin && preReading) begin
        mRows++;
        if (!preFrame && mRows >= H - 2) begin
          mReading = 0;
          expDone  = 1;
        end
      end
    end
    if (de && !rst) mPixCount = idx + 1;
    mPrevDe = rst ? 1'b0 : de;

    @(posedge clk);
    #1;
    expWren = (expBank < 0) ? 4'b0000 : 4'(1 << expBank);
    checkOutput("ctl", {24'd0, in3_wren, in2_wren, in1_wren, in0_wren, start_rd, frame_done, ovf_err, len_err},
                {24'd0, expWren, mReading, expDone, mOvf, mLen});
    if (expBank >= 0) begin
      checkOutput("wr_addr", 32'(wr_addr), 32'(idx));
      checkOutput("wr_data", 32'(wr_data), 32'(pix));
    end
    if (in0_wren) wrCnt[0]++;
    if (in1_wren) wrCnt[1]++;
    if (in2_wren) wrCnt[2]++;
    if (in3_wren) wrCnt[3]++;
    if (frame_done) doneSeen = 1;
  endtask

  // finAt in 0..len-1 pulses fin_rd with that pixel; finAt == len pulses it on the de fall.
  task automatic sendLine(input int len, input int finAt);
    for (int i = 0; i < len; i++) applyStimulus(1'b0, 1'b0, 1'b1, PW'($urandom), i == finAt);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, finAt == len);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] actW, expW;
    int r;
    //                vs finB len bank wr  st dn ovf len
    rows.push_back('{1'b1, 0,  8, 0, 8,  1'b0, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 1, 8,  1'b0, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 2, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 3, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 2,  8, 0, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 1, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 2,  0, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0});
    rows.push_back('{1'b1, 0,  8, 0, 8,  1'b0, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 1, 8,  1'b0, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 2, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 3, 8,  1'b1, 1'b0, 1'b0, 1'b0});
    rows.push_back('{1'b0, 0,  8, 0, 0,  1'b1, 1'b0, 1'b1, 1'b0});
    rows.push_back('{1'b0, 2,  8, 1, 8,  1'b1, 1'b0, 1'b1, 1'b0});
    rows.push_back('{1'b0, 2,  0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0});
    rows.push_back('{1'b1, 0, 10, 0, 8,  1'b0, 1'b0, 1'b1, 1'b1});
    rows.push_back('{1'b0, 0,  5, 1, 5,  1'b0, 1'b0, 1'b1, 1'b1});
    rows.push_back('{1'b0, 0,  8, 2, 8,  1'b1, 1'b0, 1'b1, 1'b1});
    rows.push_back('{1'b1, 0,  8, 0, 8,  1'b0, 1'b0, 1'b1, 1'b1});

    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("reset_state", {21'd0, wr_addr}, 32'd0);

    foreach (rows[i]) begin
      wrCnt = '{0, 0, 0, 0};
      doneSeen = 1'b0;
      if (rows[i].vs) begin
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end
      for (int k = 0; k < rows[i].finBefore; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end
      if (rows[i].len > 0) sendLine(rows[i].len, -1);
      actW = {8'(wrCnt[3]), 8'(wrCnt[2]), 8'(wrCnt[1]), 8'(wrCnt[0])};
      expW = 32'(rows[i].expWrites) << (8 * rows[i].expBank);
      checkOutput($sformatf("row%0d_writes", i), actW, expW);
      checkOutput($sformatf("row%0d_flags", i), {28'd0, start_rd, doneSeen, ovf_err, len_err},
                  {28'd0, rows[i].expStart, rows[i].expDone, rows[i].expOvf, rows[i].expLen});
    end

    // Reset in the middle of a line: everything clears and the rest of the line is ignored.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, PW'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PW'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PW'($urandom), 1'b0);
    checkOutput("midline_reset", {7'd0, wr_data, in3_wren, in2_wren, in1_wren, in0_wren, start_rd, frame_done, ovf_err, len_err},
                32'd0);
    wrCnt = '{0, 0, 0, 0};
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, PW'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("post_reset_wren", 32'(wrCnt[0] + wrCnt[1] + wrCnt[2] + wrCnt[3]), 32'd0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'($urandom_range(0, 1)));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end else if (r < 9) begin
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      end else if (r < 35) begin
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end else begin
        sendLine($urandom_range(1, 11), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
